pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//   Owns the program counter of the single-cycle core and sequences it.
//   Computes the next PC from sequential, branch, jump and jump-register sources
//   and handshakes each fetch with instruction memory.
//   Supports stall and halt. Sits between the control unit / branch compare and the imem port.
// PARAMETERS
//   RESET_VEC  32'h0000_0000  PC value loaded by reset
//   EXC_VEC    32'h0000_0180  exception entry PC (used only with PC_EXC_EN)
// PORTS
//   clk         in   1   core clock, rising edge
//   rst         in   1   synchronous reset, active-high
//   if_req      out  1   fetch request for the word at pc
//   if_ack      in   1   imem accepted/returned the current fetch
//   stall       in   1   hold pc even when if_ack=1
//   halt        in   1   stop fetching after the current instruction
//   br_taken    in   1   conditional branch resolved taken
//   br_offset   in   32  sign-extended branch word offset
//   jmp         in   1   J/JAL
//   jmp_target  in   26  instr_index field
//   jr          in   1   JR/JALR
//   jr_addr     in   32  register target
//   pc          out  32  current PC
//   pc_plus4    out  32  pc+4 (link value, combinational)
//   halted      out  1   1 while in HALT
//   exc_req     in   1   exception request            [PC_EXC_EN only]
//   eret        in   1   return from exception        [PC_EXC_EN only]
//   epc         out  32  saved exception PC           [PC_EXC_EN only]
// BEHAVIOUR
//   Reset (rst=1 at posedge): state=BOOT, pc=RESET_VEC, if_req=0, halted=0, epc=0.
//     rst overrides everything, in any state, including mid-fetch.
//   FSM:
//     BOOT  -> FETCH unconditionally, after exactly 1 cycle with if_req=0.
//     FETCH: if_req=1; waits in FETCH while if_ack=0; pc is held.
//       Commit = if_ack & ~stall. On commit, pc updates on the same edge.
//       Priority, highest first:
//         halt -> HALT, pc unchanged
//         [exc_req -> epc<=pc, pc<=EXC_VEC]
//         [eret -> pc<=epc]
//         jr -> pc<={jr_addr[31:2],2'b00}
//         jmp -> pc<={pc_plus4[31:28],jmp_target,2'b00}
//         br_taken -> pc<=pc_plus4+(br_offset<<2)
//         else pc<=pc_plus4
//       if_ack=1 with stall=1: no commit, pc held, if_req stays 1.
//     HALT: if_req=0, halted=1, pc frozen; all inputs ignored; exit only via rst.
//   Arithmetic: all 32-bit, modulo 2^32; pc_plus4 wraps 32'hFFFF_FFFC -> 32'h0.
//     Branch targets wrap the same way. No overflow flag.
//   Simultaneous redirects resolve by the priority above; lower ones are dropped.
//   Redirect inputs are sampled only on the commit edge; their values outside it are don't-care.
//   Throughput: one PC update per commit; min 1 cycle per instruction when if_ack is held high.
// CONFIGURATION
//   PC_EXC_EN defined:
//     exc_req/eret/epc ports and EXC_VEC exist.
//     Misaligned jr_addr (bits[1:0]!=0) on commit is treated as exc_req.
//   PC_EXC_EN undefined:
//     Those ports and epc are absent.
//     jr_addr[1:0] is silently cleared.
// TESTING
//   T1 rst 2 cycles, release, if_ack=1 -> cycle0 if_req=0 pc=0.
//      Then pc=0,4,8,C on successive edges.
//   T2 pc=0x10, if_ack=0 for 3 cycles then 1 -> pc stays 0x10 3 cycles, then 0x14.
//      Repeat with stall=1 & if_ack=1 -> pc stays 0x10.
//   T3 pc=0x20, br_taken=1 br_offset=-2 -> pc=0x1C.
//      pc=0x1000_0040, jmp=1 jmp_target=0x0000100 -> pc=0x1000_0400.
//   T4 jr=1 jmp=1 br_taken=1 jr_addr=0x0000_0203 -> pc=0x200; jmp/branch ignored.
//      With PC_EXC_EN: exc taken, pc=0x180, epc=old pc.
//   T5 pc=0xFFFF_FFFC, commit -> pc=0x0.
//      halt=1 on commit -> halted=1, if_req=0, pc frozen 10 cycles; rst -> pc=RESET_VEC.
//   T6 [PC_EXC_EN] pc=0x40, exc_req=1 -> pc=0x180, epc=0x40.
//      Then eret=1 -> pc=0x40.
//      rst asserted while if_ack=0 -> BOOT, pc=0, epc=0.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program counter sequencer: owns the PC, picks the next PC on each committed fetch, and handles halt.
// Optional exception entry/return (exc_req, eret, epc, EXC_VEC) is compiled in when PC_EXC_EN is defined.
module pc_sequencer #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000
`ifdef PC_EXC_EN
  ,
  parameter logic [31:0] EXC_VEC   = 32'h0000_0180
`endif
) (
  input  logic        clk,
  input  logic        rst,
  output logic        if_req,
  input  logic        if_ack,
  input  logic        stall,
  input  logic        halt,
  input  logic        br_taken,
  input  logic [31:0] br_offset,
  input  logic        jmp,
  input  logic [25:0] jmp_target,
  input  logic        jr,
  input  logic [31:0] jr_addr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
`ifdef PC_EXC_EN
  input  logic        exc_req,
  input  logic        eret,
  output logic [31:0] epc,
`endif
  output logic        halted,
  output logic [1:0]  fsm_state
);

  // Handshake: if_req is the fetch valid, if_ack the imem ready. A fetch commits
  // on a cycle where if_req & if_ack & ~stall; only then does the PC advance and
  // only then are the redirect inputs looked at.
  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        commit;
  logic [31:0] br_target;
  logic [31:0] jmp_dest;
  logic [31:0] jr_dest;

`ifdef PC_EXC_EN
  logic [31:0] epc_q, epc_d;
  logic        jr_misaligned;
  assign jr_misaligned = jr & (jr_addr[1:0] != 2'b00);
  assign epc           = epc_q;
`else
  // Alignment bits are dropped without a trap in this build.
  logic [3:0] unused_bits;
  assign unused_bits = {jr_addr[1:0], br_offset[31:30]};
`endif

  assign pc        = pc_q;
  assign pc_plus4  = pc_q + 32'd4;
  assign br_target = pc_plus4 + {br_offset[29:0], 2'b00};
  assign jmp_dest  = {pc_plus4[31:28], jmp_target, 2'b00};
  assign jr_dest   = {jr_addr[31:2], 2'b00};
  assign commit    = (state_q == S_FETCH) & if_ack & ~stall;
  assign fsm_state = state_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
`ifdef PC_EXC_EN
    epc_d   = epc_q;
`endif
    if_req  = 1'b0;
    halted  = 1'b0;
    case (state_q)
      S_BOOT: state_d = S_FETCH;
      S_FETCH: begin
        if_req = 1'b1;
        if (commit) begin
          if (halt) begin
            state_d = S_HALT;
`ifdef PC_EXC_EN
          end else if (exc_req | jr_misaligned) begin
            epc_d = pc_q;
            pc_d  = EXC_VEC;
          end else if (eret) begin
            pc_d = epc_q;
`endif
          end else if (jr) begin
            pc_d = jr_dest;
          end else if (jmp) begin
            pc_d = jmp_dest;
          end else if (br_taken) begin
            pc_d = br_target;
          end else begin
            pc_d = pc_plus4;
          end
        end
      end
      S_HALT: halted = 1'b1;
      default: state_d = S_BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_VEC;
`ifdef PC_EXC_EN
      epc_q   <= 32'h0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
`ifdef PC_EXC_EN
      epc_q   <= epc_d;
`endif
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus random traffic, checked cycle by cycle
// against a behavioural PC model through an expected-value queue.
module tb_pc_sequencer;

  localparam logic [31:0] RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] EXC_VEC   = 32'h0000_0180;
`ifdef PC_EXC_EN
  localparam int W = 98;
`else
  localparam int W = 66;
`endif

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        if_ack = 1'b0, stall = 1'b0, halt = 1'b0;
  logic        br_taken = 1'b0, jmp = 1'b0, jr = 1'b0;
  logic [31:0] br_offset = '0, jr_addr = '0;
  logic [25:0] jmp_target = '0;
  logic        if_req, halted;
  logic [31:0] pc, pc_plus4;
  logic [1:0]  dbg_state;
`ifdef PC_EXC_EN
  logic        exc_req = 1'b0, eret = 1'b0;
  logic [31:0] epc;
`endif

  pc_sequencer #(
    .RESET_VEC(RESET_VEC)
`ifdef PC_EXC_EN
    , .EXC_VEC(EXC_VEC)
`endif
  ) dut (
    .clk(clk), .rst(rst), .if_req(if_req), .if_ack(if_ack), .stall(stall), .halt(halt),
    .br_taken(br_taken), .br_offset(br_offset), .jmp(jmp), .jmp_target(jmp_target),
    .jr(jr), .jr_addr(jr_addr), .pc(pc), .pc_plus4(pc_plus4),
`ifdef PC_EXC_EN
    .exc_req(exc_req), .eret(eret), .epc(epc),
`endif
    .halted(halted), .fsm_state(dbg_state)
  );

  // scoreboard
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int failures = 0;
  string phase = "reset";

  // reference model: mode 0 = booting, 1 = fetching, 2 = halted
  int          m_mode = 0;
  logic [31:0] m_pc = RESET_VEC;
  logic [31:0] m_epc = '0;

  function automatic logic [W-1:0] model_outputs();
`ifdef PC_EXC_EN
    return {m_mode == 1, m_mode == 2, m_pc, m_pc + 32'd4, m_epc};
`else
    return {m_mode == 1, m_mode == 2, m_pc, m_pc + 32'd4};
`endif
  endfunction

  // Drive one cycle of inputs (called at negedge), advance the model, queue the result.
  task automatic drive(input logic r, input logic a, input logic s, input logic h,
                       input logic b, input logic [31:0] off, input logic j,
                       input logic [25:0] t, input logic jrr, input logic [31:0] ja,
                       input logic e, input logic er);
    logic [31:0] p4;
    rst = r; if_ack = a; stall = s; halt = h; br_taken = b; br_offset = off;
    jmp = j; jmp_target = t; jr = jrr; jr_addr = ja;
`ifdef PC_EXC_EN
    exc_req = e; eret = er;
`endif
    p4 = m_pc + 32'd4;
    if (r) begin
      m_mode = 0; m_pc = RESET_VEC; m_epc = '0;
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1 && a && !s) begin
      if (h) m_mode = 2;
`ifdef PC_EXC_EN
      else if (e || (jrr && ja[1:0] != 2'b00)) begin m_epc = m_pc; m_pc = EXC_VEC; end
      else if (er) m_pc = m_epc;
`endif
      else if (jrr) m_pc = ja & 32'hFFFF_FFFC;
      else if (j) m_pc = (p4 & 32'hF000_0000) | ({6'b0, t} << 2);
      else if (b) m_pc = p4 + off * 32'd4;
      else m_pc = p4;
    end
    exp_q.push_back(model_outputs());
    @(negedge clk);
  endtask

  task automatic nop(input logic a);
    drive(1'b0, a, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic jump_to(input logic [31:0] addr);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 1'b1, addr, 1'b0, 1'b0);
  endtask

  task automatic drive_random(input int halt_div, input int rst_div);
    drive($urandom_range(0, rst_div - 1) == 0, $urandom_range(0, 3) != 0,
          $urandom_range(0, 5) == 0, $urandom_range(0, halt_div - 1) == 0,
          $urandom_range(0, 3) == 0, $urandom, $urandom_range(0, 3) == 0,
          26'($urandom), $urandom_range(0, 3) == 0, $urandom,
          $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
  endtask

  // monitor: every cycle the DUT presents a new PC/status, compare against the queue head
  always @(posedge clk) begin
    logic [W-1:0] exp_v, act_v;
    #1;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
`ifdef PC_EXC_EN
      act_v = {if_req, halted, pc, pc_plus4, epc};
`else
      act_v = {if_req, halted, pc, pc_plus4};
`endif
      checks++;
      if (act_v !== exp_v) begin
        failures++;
        $display("FAIL %s @%0t {if_req,halted,pc,pc_plus4[,epc]} actual=%h required=%h",
                 phase, $time, act_v, exp_v);
      end
    end
  end

  initial begin
    @(negedge clk);
    phase = "T1_reset_count";
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    repeat (5) nop(1'b1);

    phase = "T2_wait_stall";
    jump_to(32'h10);
    repeat (3) nop(1'b0);
    nop(1'b1);
    jump_to(32'h10);
    repeat (3) drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 26'h3, 1'b1, 32'h44, 1'b0, 1'b0);
    nop(1'b1);

    phase = "T3_branch_jump";
    jump_to(32'h20);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 26'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    jump_to(32'h1000_0040);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 26'h100, 1'b0, 32'h0, 1'b0, 1'b0);

    phase = "T4_priority";
    jump_to(32'h300);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h8, 1'b1, 26'h55, 1'b1, 32'h0000_0203, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h8, 1'b1, 26'h55, 1'b0, 32'h0, 1'b0, 1'b0);

`ifdef PC_EXC_EN
    phase = "T6_exception";
    jump_to(32'h40);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h8, 1'b1, 26'h55, 1'b1, 32'h8, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h8, 1'b0, 26'h0, 1'b1, 32'h8, 1'b0, 1'b1);
    nop(1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    nop(1'b1);
`endif

    phase = "T5_wrap_halt";
    jump_to(32'hFFFF_FFFC);
    nop(1'b1);
    jump_to(32'hFFFF_FFF8);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h1, 1'b0, 26'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    jump_to(32'h80);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h4, 1'b1, 26'h7, 1'b1, 32'h400, 1'b1, 1'b1);
    repeat (10) drive_random(1, 1000000);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    nop(1'b1);

    phase = "random";
    repeat (600) drive_random(40, 60);
    nop(1'b1);

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
